tmr_voter: RTL and testbench

//  Triple-modular-redundancy majority voter: three replicas of a DataWidth bus in, voted bus out.

---
 rtl/tmr_voter_pkg.sv | 16 +
 rtl/tmr_voter_bit.sv | 25 ++
 rtl/tmr_voter.sv | 99 +++++++++
 tb/tb_tmr_voter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tmr_voter_pkg.sv
// Shared types and lane indices for the TMR majority voter.
// Replica lanes are numbered A=0, B=1, C=2 in all per-lane vectors.
package tmr_voter_pkg;

    typedef enum logic [1:0] {
        VoterClassic = 2'd0,
        VoterKp      = 2'd1,
        VoterBn      = 2'd2
    } voter_type_e;

    localparam int unsigned NumLanes = 3;
    localparam int unsigned LaneA    = 0;
    localparam int unsigned LaneB    = 1;
    localparam int unsigned LaneC    = 2;

endpackage

// File: rtl/tmr_voter_bit.sv
// Single-bit 2-of-3 majority voter.
// VOTER_TYPE picks the gate structure; every structure computes the same function.
module tmr_voter_bit
    import tmr_voter_pkg::*;
#(
    parameter int unsigned VOTER_TYPE = 0
) (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic voted_o
);

    if (VOTER_TYPE == 32'(VoterKp)) begin : g_kp
        // If A and B disagree, C breaks the tie.
        assign voted_o = (a_i ^ b_i) ? c_i : a_i;
    end else if (VOTER_TYPE == 32'(VoterBn)) begin : g_bn
        logic diff;
        assign diff    = a_i ^ b_i;
        assign voted_o = (diff & c_i) | (~diff & a_i);
    end else begin : g_classic
        assign voted_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/tmr_voter.sv
// TMR majority voter: combinational vote and per-replica mismatch flags, plus a sticky fault record.
// Define TMR_VOTER_ERR_CNT_EN to add saturating per-replica mismatch counters on err_cnt_o.
module tmr_voter
    import tmr_voter_pkg::*;
#(
    parameter int unsigned VOTER_TYPE = 0,
    parameter int unsigned DataWidth  = 1,
    parameter int unsigned CntWidth   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [DataWidth-1:0]         in_a,
    input  logic [DataWidth-1:0]         in_b,
    input  logic [DataWidth-1:0]         in_c,
    output logic [DataWidth-1:0]         out,
    output logic [NumLanes-1:0]          mismatch_o,
    output logic [NumLanes-1:0]          sticky_o,
    input  logic                         clear_i,
    output logic [NumLanes*CntWidth-1:0] err_cnt_o
);

    if (VOTER_TYPE > 32'(VoterBn)) begin : g_bad_type
        $error("tmr_voter: VOTER_TYPE %0d is not 0, 1 or 2", VOTER_TYPE);
    end

    for (genvar i = 0; i < DataWidth; i++) begin : g_bit
        tmr_voter_bit #(
            .VOTER_TYPE(VOTER_TYPE)
        ) u_bit (
            .a_i    (in_a[i]),
            .b_i    (in_b[i]),
            .c_i    (in_c[i]),
            .voted_o(out[i])
        );
    end

    assign mismatch_o[LaneA] = |(in_a ^ out);
    assign mismatch_o[LaneB] = |(in_b ^ out);
    assign mismatch_o[LaneC] = |(in_c ^ out);

    // Sticky record: clear has priority over a mismatch in the same cycle.
    logic [NumLanes-1:0] sticky_d;
    logic [NumLanes-1:0] sticky_q;

    always_comb begin
        sticky_d = sticky_q;
        if (clear_i) begin
            sticky_d = '0;
        end else begin
            sticky_d = sticky_q | mismatch_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_o = sticky_q;

`ifdef TMR_VOTER_ERR_CNT_EN
    logic [CntWidth-1:0] cnt_d [NumLanes];
    logic [CntWidth-1:0] cnt_q [NumLanes];

    // Saturating counters, one per replica, same clear priority as the sticky flags.
    always_comb begin
        for (int l = 0; l < NumLanes; l++) begin
            cnt_d[l] = cnt_q[l];
            if (clear_i) begin
                cnt_d[l] = '0;
            end else if (mismatch_o[l] && (cnt_q[l] != {CntWidth{1'b1}})) begin
                cnt_d[l] = cnt_q[l] + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int l = 0; l < NumLanes; l++) begin
                cnt_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NumLanes; l++) begin
                cnt_q[l] <= cnt_d[l];
            end
        end
    end

    for (genvar l = 0; l < NumLanes; l++) begin : g_cnt_out
        assign err_cnt_o[l*CntWidth +: CntWidth] = cnt_q[l];
    end
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tmr_voter.sv
// Scoreboard bench for tmr_voter: all three voter structures at 8-bit and 1-bit widths run side by side.
// Honours TMR_VOTER_ERR_CNT_EN for the counter expectations.
module tb_tmr_voter;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;

    logic [7:0]  out8  [3];
    logic [2:0]  mm8   [3];
    logic [2:0]  st8   [3];
    logic [5:0]  cnt8  [3];
    logic [0:0]  out1  [3];
    logic [2:0]  mm1   [3];
    logic [2:0]  st1   [3];
    logic [23:0] cnt1  [3];

    int n_total;
    int n_bad;

    typedef struct packed {
        logic [7:0]  o8;
        logic [2:0]  m8;
        logic        o1;
        logic [2:0]  m1;
        logic [2:0]  s8;
        logic [2:0]  s1;
        logic [5:0]  c8;
        logic [23:0] c1;
    } exp_t;

    exp_t sb[$];

    // Model state
    logic [2:0] s8_m;
    logic [2:0] s1_m;
    logic [1:0] c8_m [3];
    logic [7:0] c1_m [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        tmr_voter #(.VOTER_TYPE(k), .DataWidth(8), .CntWidth(2)) u8 (
            .clk_i(clk), .rst_ni(rst_n), .in_a(a), .in_b(b), .in_c(c),
            .out(out8[k]), .mismatch_o(mm8[k]), .sticky_o(st8[k]),
            .clear_i(clear), .err_cnt_o(cnt8[k])
        );
        tmr_voter #(.VOTER_TYPE(k), .DataWidth(1)) u1 (
            .clk_i(clk), .rst_ni(rst_n), .in_a(a[0]), .in_b(b[0]), .in_c(c[0]),
            .out(out1[k]), .mismatch_o(mm1[k]), .sticky_o(st1[k]),
            .clear_i(clear), .err_cnt_o(cnt1[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] maj8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            int ones;
            ones = int'(x[i]) + int'(y[i]) + int'(z[i]);
            r[i] = (ones >= 2);
        end
        return r;
    endfunction

    // Drive one vector, predict, then compare comb outputs now and registered outputs after the edge.
    task automatic apply(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
                         input logic clr, input logic rst);
        exp_t e;
        exp_t x;
        @(negedge clk);
        a = va; b = vb; c = vc; clear = clr; rst_n = rst;
        e.o8 = maj8(va, vb, vc);
        e.m8 = {(vc != e.o8), (vb != e.o8), (va != e.o8)};
        e.o1 = e.o8[0];
        e.m1 = {(vc[0] != e.o1), (vb[0] != e.o1), (va[0] != e.o1)};
        if (!rst || clr) begin
            s8_m = '0;
            s1_m = '0;
            for (int l = 0; l < 3; l++) begin
                c8_m[l] = '0;
                c1_m[l] = '0;
            end
        end else begin
            s8_m = s8_m | e.m8;
            s1_m = s1_m | e.m1;
`ifdef TMR_VOTER_ERR_CNT_EN
            for (int l = 0; l < 3; l++) begin
                if (e.m8[l] && c8_m[l] != 2'd3)   c8_m[l] = c8_m[l] + 2'd1;
                if (e.m1[l] && c1_m[l] != 8'hFF) c1_m[l] = c1_m[l] + 8'd1;
            end
`endif
        end
        e.s8 = s8_m;
        e.s1 = s1_m;
        e.c8 = {c8_m[2], c8_m[1], c8_m[0]};
        e.c1 = {c1_m[2], c1_m[1], c1_m[0]};
        sb.push_back(e);
        #1;
        x = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out8[%0d]", k), 32'(out8[k]), 32'(x.o8));
            check($sformatf("mm8[%0d]", k),  32'(mm8[k]),  32'(x.m8));
            check($sformatf("out1[%0d]", k), 32'(out1[k]), 32'(x.o1));
            check($sformatf("mm1[%0d]", k),  32'(mm1[k]),  32'(x.m1));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sticky8[%0d]", k), 32'(st8[k]),  32'(x.s8));
            check($sformatf("sticky1[%0d]", k), 32'(st1[k]),  32'(x.s1));
            check($sformatf("cnt8[%0d]", k),    32'(cnt8[k]), 32'(x.c8));
            check($sformatf("cnt1[%0d]", k),    32'(cnt1[k]), 32'(x.c1));
        end
    endtask

    initial begin
        logic [2:0] pats [8];
        n_total = 0;
        n_bad   = 0;
        s8_m = '0;
        s1_m = '0;
        for (int l = 0; l < 3; l++) begin
            c8_m[l] = '0;
            c1_m[l] = '0;
        end
        a = '0; b = '0; c = '0; clear = 1'b0; rst_n = 1'b0;

        // Reset state
        apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Truth table, patterns as {c,b,a}
        pats = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111, 3'b110, 3'b101, 3'b011};
        for (int p = 0; p < 8; p++) begin
            apply({8{pats[p][0]}}, {8{pats[p][1]}}, {8{pats[p][2]}}, 1'b0, 1'b1);
        end

        // A alone high: flag, then sticky holds once inputs agree
        apply(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        apply(8'h01, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t2_sticky_a", 32'(st8[0]), 32'h1);
        apply(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        check("t2_sticky_hold", 32'(st8[0]), 32'h1);

        // Clear beats a same-cycle mismatch; reset mid-run leaves the vote alone
        apply(8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
        check("t3_clear_wins", 32'(st8[0]), 32'h0);
        apply(8'h00, 8'h01, 8'h00, 1'b0, 1'b1);
        apply(8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
        check("t3_reset", 32'(st8[0]), 32'h0);
        check("t3_out_in_reset", 32'(out8[0]), 32'h01);

        // Multi-bit cases with one and two flagged lanes
        apply(8'hFF, 8'hFF, 8'h0F, 1'b0, 1'b1);
        apply(8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1);

        // B mismatch held long enough to saturate a 2-bit counter, then clear
        apply(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            apply(8'h00, 8'h01, 8'h00, 1'b0, 1'b1);
        end
`ifdef TMR_VOTER_ERR_CNT_EN
        check("t5_cnt_sat", 32'(cnt8[0]), 32'h0C);
`else
        check("t5_cnt_off", 32'(cnt8[0]), 32'h00);
`endif
        apply(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);

        // Random vectors with occasional clear and reset
        for (int n = 0; n < 1000; n++) begin
            apply(8'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
